// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: queues X/Y requests from the vending machine, drives the product
// motor and change hopper for fixed durations, and confirms each with a drop sensor under a timeout.
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int HOPPER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          X,
    input  logic                          Y,
    input  logic                          product_sensor,
    input  logic                          coin_sensor,
    input  logic                          fault_clear,
    output logic                          motor_on,
    output logic                          hopper_on,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          overflow,
    output logic                          fault,
    output logic [1:0]                    fault_code
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_CYC = (MOTOR_CYCLES > HOPPER_CYCLES)
                           ? ((MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES)
                           : ((HOPPER_CYCLES > TIMEOUT_CYCLES) ? HOPPER_CYCLES : TIMEOUT_CYCLES);
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MOTOR_LAST   = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] HOPPER_LAST  = CW'(HOPPER_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT     = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_WAIT_DROP,
        S_HOPPER,
        S_WAIT_COIN,
        S_FAULT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            drop_seen, drop_seen_n;
    logic            coin_seen, coin_seen_n;
    logic            chg_flag, chg_flag_n;
    logic [1:0]      code_n;

    logic            fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            x_prev;
    logic            x_rise, full, push, pop;
    logic [AW:0]     count_n;

    // A request is the rising edge of X; x_prev resets high so a held X is not a request.
    assign x_rise = X & ~x_prev;
    assign full   = (pending == FULL_CNT);
    assign push   = x_rise & (~full | pop);

    always_comb begin
        case ({push, pop})
            2'b10:   count_n = pending + (AW+1)'(1);
            2'b01:   count_n = pending - (AW+1)'(1);
            default: count_n = pending;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        drop_seen_n = drop_seen;
        coin_seen_n = coin_seen;
        chg_flag_n  = chg_flag;
        code_n      = fault_code;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    pop         = 1'b1;
                    chg_flag_n  = fifo_mem[rd_ptr];
                    drop_seen_n = 1'b0;
                    coin_seen_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = S_MOTOR;
                end
            end
            S_MOTOR: begin
                if (product_sensor) drop_seen_n = 1'b1;
                if (cnt == MOTOR_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WAIT_DROP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_DROP: begin
                if (drop_seen || product_sensor) begin
                    cnt_n   = '0;
                    state_n = chg_flag ? S_HOPPER : S_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_n   = '0;
                    code_n  = 2'b01;
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HOPPER: begin
                if (coin_sensor) coin_seen_n = 1'b1;
                if (cnt == HOPPER_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WAIT_COIN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_COIN: begin
                if (coin_seen || coin_sensor) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_n   = '0;
                    code_n  = 2'b10;
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_FAULT: begin
                if (fault_clear) begin
                    code_n  = 2'b00;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            drop_seen  <= 1'b0;
            coin_seen  <= 1'b0;
            chg_flag   <= 1'b0;
            x_prev     <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            motor_on   <= 1'b0;
            hopper_on  <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            drop_seen  <= drop_seen_n;
            coin_seen  <= coin_seen_n;
            chg_flag   <= chg_flag_n;
            x_prev     <= X;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            pending    <= count_n;
            overflow   <= overflow | (x_rise & full & ~pop);
            // Outputs are registered from the next-state decode so they track the state register.
            motor_on   <= (state_n == S_MOTOR);
            hopper_on  <= (state_n == S_HOPPER);
            busy       <= (state_n != S_IDLE) || (count_n != '0);
            fault      <= (state_n == S_FAULT);
            fault_code <= code_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= Y;
    end

endmodule
